// File: rtl/hbridge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : hbridge_monitor
// Purpose  : Observes a 4-bit H-bridge gate drive. Measures duty/direction
//            over a free-running window of PERIOD cycles and flags illegal
//            gate patterns and direction reversals with too little dead time.
// Ports    : clk            - rising-edge clock
//            reset_n        - asynchronous active-low reset
//            gate[3:0]      - gate drive under observation
//            clear_faults   - synchronous clear of sticky fault flags
//            duty[5:0]      - active samples in last completed window
//            dir            - 1 = forward (1001), 0 = reverse (0110)
//            on             - last window had at least one active sample
//            dir_mixed      - last window saw both directions
//            duty_valid     - one-cycle pulse when window results update
//            fault_illegal  - sticky: non-legal gate pattern seen
//            fault_deadtime - sticky: reversal with short dead time
// Revision : 1.0 - initial release
// ============================================================================
module hbridge_monitor #(
    parameter int PERIOD    = 32,
    parameter int DEAD_TIME = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] gate,
    input  logic       clear_faults,
    output logic [5:0] duty,
    output logic       dir,
    output logic       on,
    output logic       dir_mixed,
    output logic       duty_valid,
    output logic       fault_illegal,
    output logic       fault_deadtime
);

    localparam int WIN_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int IDLE_W = $clog2(DEAD_TIME + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(PERIOD - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DEAD_TIME);

    localparam logic [3:0] PAT_IDLE = 4'b0000;
    localparam logic [3:0] PAT_FWD  = 4'b1001;
    localparam logic [3:0] PAT_REV  = 4'b0110;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_FWD  = 2'd1,
        DIR_REV  = 2'd2
    } last_dir_e;

    logic [3:0]        g_q,        g_d;
    logic [WIN_W-1:0]  win_q,      win_d;
    logic [5:0]        acc_q,      acc_d;
    logic              seen_fwd_q, seen_fwd_d;
    logic              seen_rev_q, seen_rev_d;
    logic              win_dir_q,  win_dir_d;
    logic [5:0]        duty_q,     duty_d;
    logic              dir_q,      dir_d;
    logic              on_q,       on_d;
    logic              mixed_q,    mixed_d;
    logic              valid_q,    valid_d;
    logic              f_ill_q,    f_ill_d;
    logic              f_dt_q,     f_dt_d;
    logic [IDLE_W-1:0] idle_q,     idle_d;
    last_dir_e         last_q,     last_d;

    logic       w_fwd, w_rev, w_idle, w_act, w_ill;
    logic       w_win_end, w_reversal;
    logic [5:0] w_sum;

    always_comb begin
        w_fwd      = (g_q == PAT_FWD);
        w_rev      = (g_q == PAT_REV);
        w_idle     = (g_q == PAT_IDLE);
        w_act      = w_fwd | w_rev;
        w_ill      = ~(w_act | w_idle);
        w_win_end  = (win_q == WIN_LAST);
        w_sum      = acc_q + 6'(w_act);
        // Reversal only counts against a known previous direction, so the
        // first activation after reset (last = NONE) never faults.
        w_reversal = ((w_fwd && last_q == DIR_REV) || (w_rev && last_q == DIR_FWD))
                     && (idle_q < IDLE_MAX);

        g_d        = gate;
        win_d      = win_q + WIN_W'(1);
        acc_d      = w_sum;
        seen_fwd_d = seen_fwd_q | w_fwd;
        seen_rev_d = seen_rev_q | w_rev;
        win_dir_d  = w_act ? w_fwd : win_dir_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        on_d       = on_q;
        mixed_d    = mixed_q;
        valid_d    = 1'b0;
        idle_d     = idle_q;
        last_d     = last_q;

        if (w_win_end) begin
            // Results include the sample classified on the closing cycle.
            win_d      = '0;
            acc_d      = '0;
            seen_fwd_d = 1'b0;
            seen_rev_d = 1'b0;
            duty_d     = w_sum;
            on_d       = (w_sum != 6'd0);
            mixed_d    = (seen_fwd_q | w_fwd) & (seen_rev_q | w_rev);
            valid_d    = 1'b1;
            if (w_act) begin
                dir_d = w_fwd;
            end else if (seen_fwd_q | seen_rev_q) begin
                dir_d = win_dir_q;
            end
        end

        if (w_idle) begin
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end else begin
            idle_d = '0;
        end

        if (w_fwd) begin
            last_d = DIR_FWD;
        end else if (w_rev) begin
            last_d = DIR_REV;
        end

        // A new fault event overrides a simultaneous clear.
        f_ill_d = w_ill      | (f_ill_q & ~clear_faults);
        f_dt_d  = w_reversal | (f_dt_q  & ~clear_faults);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            g_q        <= PAT_IDLE;
            win_q      <= '0;
            acc_q      <= '0;
            seen_fwd_q <= 1'b0;
            seen_rev_q <= 1'b0;
            win_dir_q  <= 1'b0;
            duty_q     <= '0;
            dir_q      <= 1'b0;
            on_q       <= 1'b0;
            mixed_q    <= 1'b0;
            valid_q    <= 1'b0;
            f_ill_q    <= 1'b0;
            f_dt_q     <= 1'b0;
            idle_q     <= IDLE_MAX;
            last_q     <= DIR_NONE;
        end else begin
            g_q        <= g_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            seen_fwd_q <= seen_fwd_d;
            seen_rev_q <= seen_rev_d;
            win_dir_q  <= win_dir_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            on_q       <= on_d;
            mixed_q    <= mixed_d;
            valid_q    <= valid_d;
            f_ill_q    <= f_ill_d;
            f_dt_q     <= f_dt_d;
            idle_q     <= idle_d;
            last_q     <= last_d;
        end
    end

    assign duty           = duty_q;
    assign dir            = dir_q;
    assign on             = on_q;
    assign dir_mixed      = mixed_q;
    assign duty_valid     = valid_q;
    assign fault_illegal  = f_ill_q;
    assign fault_deadtime = f_dt_q;

endmodule
`default_nettype wire

// File: tb/tb_hbridge_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_hbridge_monitor
// Purpose  : Directed bench for hbridge_monitor. Stimulus is issued in whole
//            windows of 32 gate values; each window's expected result is
//            queued and a negedge monitor pops and compares on duty_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hbridge_monitor;

    localparam logic [3:0] G_IDLE = 4'b0000;
    localparam logic [3:0] G_FWD  = 4'b1001;
    localparam logic [3:0] G_REV  = 4'b0110;
    localparam logic [3:0] G_BAD  = 4'b1111;

    typedef struct packed {
        logic [5:0] duty;
        logic       dir;
        logic       on;
        logic       mixed;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] gate;
    logic       clear_faults;
    logic [5:0] duty;
    logic       dir;
    logic       on;
    logic       dir_mixed;
    logic       duty_valid;
    logic       fault_illegal;
    logic       fault_deadtime;

    int   tests = 0;
    int   fails = 0;
    int   win_idx = 0;
    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    hbridge_monitor #(.PERIOD(32), .DEAD_TIME(500)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .gate           (gate),
        .clear_faults   (clear_faults),
        .duty           (duty),
        .dir            (dir),
        .on             (on),
        .dir_mixed      (dir_mixed),
        .duty_valid     (duty_valid),
        .fault_illegal  (fault_illegal),
        .fault_deadtime (fault_deadtime)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input bit di, input bit o, input bit m);
        exp_t e;
        e.duty  = 6'(d);
        e.dir   = di;
        e.on    = o;
        e.mixed = m;
        sbq.push_back(e);
    endtask

    // One gate value per clock; inputs change 1 time unit after the edge.
    task automatic cyc(input logic [3:0] g, input logic clr);
        gate         = g;
        clear_faults = clr;
        @(posedge clk);
        #1;
        clear_faults = 1'b0;
    endtask

    task automatic seg(input logic [3:0] g, input int n);
        repeat (n) cyc(g, 1'b0);
    endtask

    task automatic idle_win(input bit d, input int n);
        repeat (n) begin
            push(0, d, 0, 0);
            seg(G_IDLE, 32);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && duty_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: duty_valid in window %0d, expected none", win_idx);
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("win%0d_duty", win_idx),  int'(duty),      int'(mon_e.duty));
                chk($sformatf("win%0d_dir", win_idx),   int'(dir),       int'(mon_e.dir));
                chk($sformatf("win%0d_on", win_idx),    int'(on),        int'(mon_e.on));
                chk($sformatf("win%0d_mixed", win_idx), int'(dir_mixed), int'(mon_e.mixed));
            end
            win_idx++;
        end
    end

    initial begin
        int  k;
        bit  got;
        reset_n      = 1'b0;
        gate         = G_IDLE;
        clear_faults = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty",  int'(duty),           0);
        chk("rst_dir",   int'(dir),            0);
        chk("rst_on",    int'(on),             0);
        chk("rst_mixed", int'(dir_mixed),      0);
        chk("rst_valid", int'(duty_valid),     0);
        chk("rst_fill",  int'(fault_illegal),  0);
        chk("rst_fdt",   int'(fault_deadtime), 0);
        reset_n = 1'b1;

        // First window: the reset value of the input register is its first
        // sample, so only 31 gate values land in it.
        push(0, 0, 0, 0); seg(G_IDLE, 31);

        // 10/32 forward PWM at three phases, including one straddling a
        // window boundary.
        push(10, 1, 1, 0); seg(G_FWD, 10); seg(G_IDLE, 22);
        push(10, 1, 1, 0); seg(G_IDLE, 7); seg(G_FWD, 10); seg(G_IDLE, 15);
        push(10, 1, 1, 0); seg(G_FWD, 5); seg(G_IDLE, 22); seg(G_FWD, 5);
        push(5, 1, 1, 0);  seg(G_FWD, 5); seg(G_IDLE, 27);
        idle_win(1, 1);

        // Forward, 499 idle samples, then reverse: dead-time violation.
        push(1, 1, 1, 0); seg(G_FWD, 1); seg(G_IDLE, 31);
        idle_win(1, 14);
        chk("dt_same_dir_ok", int'(fault_deadtime), 0);
        push(1, 0, 1, 0); seg(G_IDLE, 20); seg(G_REV, 1); seg(G_IDLE, 11);
        chk("dt_499_idle", int'(fault_deadtime), 1);

        // Clear, then exactly 500 idle samples before forward: legal.
        push(0, 0, 0, 0); cyc(G_IDLE, 1'b1); seg(G_IDLE, 31);
        chk("dt_cleared", int'(fault_deadtime), 0);
        idle_win(0, 14);
        push(1, 1, 1, 0); seg(G_IDLE, 9); seg(G_FWD, 1); seg(G_IDLE, 22);
        chk("dt_500_idle", int'(fault_deadtime), 0);

        // Illegal pattern: not counted, sticky, event beats clear.
        push(0, 1, 0, 0); seg(G_IDLE, 5); seg(G_BAD, 1); seg(G_IDLE, 26);
        chk("ill_set", int'(fault_illegal), 1);
        push(0, 1, 0, 0); seg(G_IDLE, 5); cyc(G_BAD, 1'b0); cyc(G_IDLE, 1'b1); seg(G_IDLE, 25);
        chk("ill_event_beats_clear", int'(fault_illegal), 1);
        push(0, 1, 0, 0); cyc(G_IDLE, 1'b1); seg(G_IDLE, 31);
        chk("ill_cleared", int'(fault_illegal), 0);

        // 3 forward then 4 reverse back-to-back.
        push(7, 0, 1, 1); seg(G_IDLE, 5); seg(G_FWD, 3); seg(G_REV, 4); seg(G_IDLE, 20);
        chk("dt_mixed_window", int'(fault_deadtime), 1);

        // Reverse held for a whole window.
        push(32, 0, 1, 0); seg(G_REV, 32);

        // Reset with the window counter at 17; the partial window is lost.
        seg(G_FWD, 18);
        reset_n = 1'b0;
        #2;
        chk("rst2_duty",  int'(duty),           0);
        chk("rst2_on",    int'(on),             0);
        chk("rst2_valid", int'(duty_valid),     0);
        chk("rst2_fdt",   int'(fault_deadtime), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        push(31, 0, 1, 0);
        k   = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(G_REV, 1'b0);
            k++;
            if (duty_valid === 1'b1) got = 1'b1;
        end
        chk("rst_to_first_valid", k, 32);

        push(10, 0, 1, 0); seg(G_REV, 9); seg(G_IDLE, 22);
        chk("first_act_no_fault", int'(fault_deadtime), 0);

        seg(G_IDLE, 3);
        chk("sb_drain", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
